// File: rtl/button_debouncer.sv
// Multi-channel push-button front end: 2-FF synchronizer plus per-channel stability FSM,
// active-low debounced levels with edge strobes. Optional long-press strobe via LONG_PRESS_EN.
module button_debouncer #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int LONG_CYCLES     = 2000000,
  parameter int LCNT_W          = 21
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [NUM_BTN-1:0] Btn_raw,
  output logic [NUM_BTN-1:0] Btn_out,
  output logic [NUM_BTN-1:0] Btn_changed,
  output logic [NUM_BTN-1:0] Btn_long
);

  typedef enum logic {
    S_STABLE = 1'b0,
    S_CHECK  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || (2 ** CNT_W) <= DEBOUNCE_CYCLES) begin : g_bad_cnt
    $error("button_debouncer: DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
  end
  if (LONG_CYCLES < 2 || (2 ** LCNT_W) <= LONG_CYCLES) begin : g_bad_lcnt
    $error("button_debouncer: LONG_CYCLES must be >= 2 and fit in LCNT_W bits");
  end

  logic [NUM_BTN-1:0] sync1_r;
  logic [NUM_BTN-1:0] sync2_r;

  // Two-flop synchronizer; idles released (1) so reset never looks like a press.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sync1_r <= {NUM_BTN{1'b1}};
      sync2_r <= {NUM_BTN{1'b1}};
    end else begin
      sync1_r <= Btn_raw;
      sync2_r <= sync1_r;
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             out_r;
    logic             out_s;
    logic             chg_r;
    logic             chg_s;
    logic             diff_s;

    assign diff_s = sync2_r[g] ^ out_r;

    // Next-state logic: count consecutive clocks where the synchronized level disagrees.
    always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      out_s   = out_r;
      chg_s   = 1'b0;
      case (state_r)
        S_STABLE: begin
          if (diff_s) begin
            state_s = S_CHECK;
            cnt_s   = CNT_ONE;
          end else begin
            state_s = S_STABLE;
            cnt_s   = CNT_ZERO;
          end
        end
        S_CHECK: begin
          if (!diff_s) begin
            state_s = S_STABLE;
            cnt_s   = CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            // Acceptance point: counter stops here instead of wrapping.
            state_s = S_STABLE;
            cnt_s   = CNT_ZERO;
            out_s   = ~out_r;
            chg_s   = 1'b1;
          end else begin
            cnt_s   = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_s = S_STABLE;
          cnt_s   = CNT_ZERO;
        end
      endcase
    end

    // Channel state, counter and registered outputs.
    always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
        state_r <= S_STABLE;
        cnt_r   <= CNT_ZERO;
        out_r   <= 1'b1;
        chg_r   <= 1'b0;
      end else begin
        state_r <= state_s;
        cnt_r   <= cnt_s;
        out_r   <= out_s;
        chg_r   <= chg_s;
      end
    end

    assign Btn_out[g]     = out_r;
    assign Btn_changed[g] = chg_r;

`ifdef LONG_PRESS_EN
    localparam logic [LCNT_W-1:0] HCNT_ZERO = {LCNT_W{1'b0}};
    localparam logic [LCNT_W-1:0] HCNT_ONE  = LCNT_W'(1);
    localparam logic [LCNT_W-1:0] HCNT_SAT  = LCNT_W'(LONG_CYCLES);
    localparam logic [LCNT_W-1:0] HCNT_LAST = LCNT_W'(LONG_CYCLES - 1);

    logic [LCNT_W-1:0] hcnt_r;
    logic [LCNT_W-1:0] hcnt_s;
    logic              long_r;
    logic              long_s;

    // Hold counter: restarts on every debounced edge, saturates so the strobe fires once per press.
    always_comb begin
      hcnt_s = hcnt_r;
      long_s = 1'b0;
      if (chg_s || out_r) begin
        hcnt_s = HCNT_ZERO;
      end else if (hcnt_r != HCNT_SAT) begin
        hcnt_s = hcnt_r + HCNT_ONE;
        long_s = (hcnt_r == HCNT_LAST);
      end else begin
        hcnt_s = hcnt_r;
      end
    end

    // Hold counter and long-press strobe registers.
    always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
        hcnt_r <= HCNT_ZERO;
        long_r <= 1'b0;
      end else begin
        hcnt_r <= hcnt_s;
        long_r <= long_s;
      end
    end

    assign Btn_long[g] = long_r;
`else
    assign Btn_long[g] = 1'b0;
`endif
  end

endmodule
